// File: rtl/loader_pkg.sv
// Shared definitions for the program loaders.
//   state_t    : loader FSM encoding (S_IDLE .. S_ERR)
//   LEN_BYTES  : bytes in the little-endian length header
//   CSUM_W     : checksum accumulator width
package loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int LEN_BYTES = 4;
    localparam int CSUM_W    = 8;
endpackage

// File: rtl/loader_csum.sv
// Running modulo-2**CSUM_W byte sum for a loader payload.
//   clk, rst    : clock, synchronous active-low reset
//   clear       : zero the sum (takes priority over add_en)
//   add_en      : add byte_in this cycle
//   byte_in     : payload byte
//   sum         : current sum
module loader_csum
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [CSUM_W-1:0] byte_in,
    output logic [CSUM_W-1:0] sum
);
    always_ff @(posedge clk) begin
        if (!rst)        sum <= '0;
        else if (clear)  sum <= '0;
        else if (add_en) sum <= sum + byte_in;
    end
endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader feeding the instruction memory write port.
// Frame: 4-byte little-endian length, payload, 1-byte checksum (sum mod 256).
// Payload byte i goes to BASE_ADDR+i; the core is held in reset until a
// load completes with a matching checksum.
//   clk, rst            : clock, synchronous active-low reset
//   start               : begin a load (only from IDLE/DONE/ERR)
//   in_valid/in_data    : stream byte, consumed when in_valid & in_ready
//   in_ready            : high in LEN/DATA/CSUM
//   mem_we/addr/wdata   : one-cycle byte write, issued the cycle after accept
//   busy, done, err     : load in progress / verified / failed (sticky)
//   core_rst_n          : core reset, released only in DONE
//   bytes_wr            : payload bytes written in current/last load
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_rst_n,
    output logic [ADDR_W:0]   bytes_wr
);
    // Largest payload that fits between BASE_ADDR and the top of memory,
    // so mem_addr can never wrap.
    localparam logic [32:0] LEN_MAX = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

    state_t              state;
    logic [31:0]         len_q;
    logic [1:0]          len_idx;
    logic [31:0]         len_next;
    logic [CSUM_W-1:0]   csum;
    logic                accept;
    logic                start_ok;
    logic [ADDR_W:0]     bytes_nxt;

    assign accept    = in_valid & in_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign bytes_nxt = bytes_wr + 1'b1;

    always_comb begin
        len_next = len_q;
        len_next[{len_idx, 3'b000} +: 8] = in_data;
    end

    loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .add_en  (accept && state == S_DATA),
        .byte_in (in_data),
        .sum     (csum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            len_idx    <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            bytes_wr   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        state      <= S_LEN;
                        len_idx    <= '0;
                        len_q      <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        bytes_wr   <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        core_rst_n <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_q   <= len_next;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'(LEN_BYTES - 1)) begin
                            if ({1'b0, len_next} > LEN_MAX) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                            end else if (len_next == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(BASE_ADDR) + bytes_wr[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        bytes_wr  <= bytes_nxt;
                        if (64'(bytes_nxt) == 64'(len_q)) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        rdy_a, we_a, busy_a, done_a, err_a, crn_a;
    logic [19:0] addr_a;
    logic [7:0]  wdata_a;
    logic [20:0] bw_a;

    logic        rdy_b, we_b, busy_b, done_b, err_b, crn_b;
    logic [3:0]  addr_b;
    logic [7:0]  wdata_b;
    logic [4:0]  bw_b;

    int total = 0, bad = 0;
    bit sel = 1'b0;              // 0 drives the 20-bit instance, 1 the 4-bit one
    logic [7:0] pay [0:31];
    int tmo = 0;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(20), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a), .core_rst_n(crn_a), .bytes_wr(bw_a));

    instr_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b), .core_rst_n(crn_b), .bytes_wr(bw_b));

    // Write monitors: capture each handshake, then expect the write one cycle later.
    logic       hs_a = 1'b0, hs_b = 1'b0;
    logic [7:0] hs_byte_a = 8'h00;
    always @(posedge clk) begin
        hs_a      <= in_valid & rdy_a;
        hs_b      <= in_valid & rdy_b;
        hs_byte_a <= in_data;
    end

    int wr_a = 0, base_a = 0, werr_a = 0, wr_b = 0;
    logic [7:0] mem_m [0:255];
    logic [3:0] last_b = 4'h0;
    always @(negedge clk) begin
        if (we_a) begin
            if (!hs_a || wdata_a != hs_byte_a || addr_a != 20'(wr_a - base_a)) werr_a++;
            if (addr_a < 20'd256) mem_m[addr_a[7:0]] = wdata_a;
            wr_a++;
        end
        if (we_b) begin
            if (!hs_b) werr_a++;
            last_b = addr_b;
            wr_b++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start(input bit with_byte);
        @(negedge clk);
        base_a = wr_a;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        @(negedge clk);
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!(sel ? rdy_b : rdy_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) tmo++;
        else @(posedge clk);
    endtask

    task automatic send_len(input logic [31:0] len);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [31:0] len, input int n, input logic [7:0] cs,
                              input bit gaps);
        pulse_start(1'b0);
        send_len(len);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            send_byte(pay[i]);
        end
        send_byte(cs);
        idle(2);
    endtask

    task automatic load_nominal();
        pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
        pay[4] = 8'h93; pay[5] = 8'h00; pay[6] = 8'h10; pay[7] = 8'h00;
    endtask

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_core", crn_a, 0);
        chk("rst_bw", bw_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_addr", addr_a, 0);
        rst = 1'b1;
        idle(2);

        // Nominal frame; a byte offered in the start cycle must not be consumed.
        load_nominal();
        pulse_start(1'b1);
        chk("ld_rdy", rdy_a, 1);
        chk("ld_busy", busy_a, 1);
        chk("ld_core", crn_a, 0);
        send_len(32'd8);
        for (int i = 0; i < 8; i++) send_byte(pay[i]);
        send_byte(8'hB6);
        idle(2);
        chk("nom_done", done_a, 1);
        chk("nom_err", err_a, 0);
        chk("nom_core", crn_a, 1);
        chk("nom_bw", bw_a, 8);
        chk("nom_writes", wr_a - base_a, 8);
        chk("nom_rdy", rdy_a, 0);
        chk("nom_busy", busy_a, 0);
        chk("nom_fetch0", {mem_m[3], mem_m[2], mem_m[1], mem_m[0]}, 32'h0000_0013);
        chk("nom_fetch4", {mem_m[7], mem_m[6], mem_m[5], mem_m[4]}, 32'h0010_0093);

        // Bad checksum
        send_frame(32'd8, 8, 8'hB7, 1'b0);
        chk("bad_writes", wr_a - base_a, 8);
        chk("bad_err", err_a, 1);
        chk("bad_done", done_a, 0);
        chk("bad_core", crn_a, 0);

        // Zero length, good then bad checksum
        send_frame(32'd0, 0, 8'h00, 1'b0);
        chk("z_writes", wr_a - base_a, 0);
        chk("z_done", done_a, 1);
        chk("z_bw", bw_a, 0);
        send_frame(32'd0, 0, 8'h01, 1'b0);
        chk("z_err", err_a, 1);
        chk("z_done1", done_a, 0);

        // Random bubbles on in_valid
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        pay[3] = 8'hD4; pay[4] = 8'hE5; pay[5] = 8'hF6;
        send_frame(32'd6, 6, 8'hC5, 1'b1);
        chk("gap_done", done_a, 1);
        chk("gap_writes", wr_a - base_a, 6);
        chk("gap_mem", {mem_m[5], mem_m[4], mem_m[3], mem_m[2], mem_m[1], mem_m[0]},
            48'hF6E5D4C3B2A1);

        // Reset after 3 of 8 payload bytes
        load_nominal();
        pulse_start(1'b0);
        send_len(32'd8);
        for (int i = 0; i < 3; i++) send_byte(pay[i]);
        idle(2);
        chk("mid_writes", wr_a - base_a, 3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        w0 = wr_a;
        idle(5);
        chk("mid_nowr", wr_a - w0, 0);
        chk("mid_bw", bw_a, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_rdy", rdy_a, 0);
        send_frame(32'd8, 8, 8'hB6, 1'b0);
        chk("mid_done", done_a, 1);
        chk("mid_writes2", wr_a - base_a, 8);

        // Small memory: overflow by one, then exactly full
        sel = 1'b1;
        pulse_start(1'b0);
        send_len(32'd17);
        idle(2);
        chk("ovf_err", err_b, 1);
        chk("ovf_writes", wr_b, 0);
        chk("ovf_rdy", rdy_b, 0);
        chk("ovf_busy", busy_b, 0);
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        send_frame(32'd16, 16, 8'h88, 1'b0);
        chk("full_done", done_b, 1);
        chk("full_writes", wr_b, 16);
        chk("full_top", last_b, 4'hF);
        chk("full_bw", bw_b, 16);

        chk("we_errs", werr_a, 0);
        chk("timeouts", tmo, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
